// File: rtl/svc_axi_wr_sched.sv
// Write-path scheduler for an N:1 AXI arbiter: round-robin AW grant, in-order
// grant FIFO, and W-channel steering to the manager at the FIFO head.
module svc_axi_wr_sched #(
  parameter  int NUM_M       = 2,
  parameter  int GRANT_DEPTH = 4,
  localparam int IDX_W       = $clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] s_axi_awvalid,
  output logic [NUM_M-1:0] s_axi_awready,
  input  logic [NUM_M-1:0] s_axi_wvalid,
  input  logic [NUM_M-1:0] s_axi_wlast,
  output logic [NUM_M-1:0] s_axi_wready,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  output logic [IDX_W-1:0] aw_sel,
  output logic [IDX_W-1:0] w_sel,
  output logic             w_sel_valid
);

  localparam int PTR_W = $clog2(GRANT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {AW_IDLE, AW_HOLD} aw_state_e;

  aw_state_e        state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_pick;
  logic             any_req;
  logic             fifo_full;
  logic             grant_start;
  logic             aw_push;
  logic             w_pop;

  logic [IDX_W-1:0] grant_mem [GRANT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign any_req     = |s_axi_awvalid;
  assign fifo_full   = (count == CNT_W'(GRANT_DEPTH));
  assign grant_start = (state == AW_IDLE) && any_req && !fifo_full;
  assign aw_push     = m_axi_awvalid && m_axi_awready;

  // First requester at or after rr_ptr, wrapping modulo NUM_M.
  always_comb begin : rr_arb
    int  cand;
    logic found;
    rr_pick = rr_ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!found && s_axi_awvalid[IDX_W'(cand)]) begin
        rr_pick = IDX_W'(cand);
        found   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= AW_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AW_IDLE: if (grant_start) state_nxt = AW_HOLD;
      AW_HOLD: if (aw_push)     state_nxt = AW_IDLE;
      default:                  state_nxt = AW_IDLE;
    endcase
  end

  // NOTE: each combinational output gets a default first so no path infers a latch.
  always_comb begin
    m_axi_awvalid = 1'b0;
    s_axi_awready = '0;
    if (state == AW_HOLD) begin
      m_axi_awvalid         = 1'b1;
      s_axi_awready[aw_sel] = m_axi_awready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_sel <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant_start) aw_sel <= rr_pick;
      if (aw_push)     rr_ptr <= (aw_sel == IDX_W'(NUM_M - 1)) ? '0 : aw_sel + IDX_W'(1);
    end
  end

  assign w_sel_valid = (count != '0);
  assign w_sel       = w_sel_valid ? grant_mem[rd_ptr] : '0;

  always_comb begin
    m_axi_wvalid = 1'b0;
    s_axi_wready = '0;
    if (w_sel_valid) begin
      m_axi_wvalid        = s_axi_wvalid[w_sel];
      s_axi_wready[w_sel] = m_axi_wready;
    end
  end

  assign w_pop = m_axi_wvalid && m_axi_wready && s_axi_wlast[w_sel];

  // NOTE: the grant storage is not reset; count gates every read, so stale
  // entries are never observed.
  always_ff @(posedge clk) begin
    if (aw_push) grant_mem[wr_ptr] <= aw_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (aw_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (w_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({aw_push, w_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_axi_wr_sched.sv
// Bench for svc_axi_wr_sched: expected grants are queued as stimulus is driven
// and checked on each AW handshake; a grant-order model checks W steering.
module tb_svc_axi_wr_sched;

  localparam int NUM_M       = 2;
  localparam int GRANT_DEPTH = 4;
  localparam int IDX_W       = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NUM_M-1:0] s_axi_awvalid = '0;
  logic [NUM_M-1:0] s_axi_awready;
  logic [NUM_M-1:0] s_axi_wvalid = '0;
  logic [NUM_M-1:0] s_axi_wlast = '0;
  logic [NUM_M-1:0] s_axi_wready;
  logic             m_axi_awvalid;
  logic             m_axi_awready = 1'b0;
  logic             m_axi_wvalid;
  logic             m_axi_wready = 1'b0;
  logic [IDX_W-1:0] aw_sel;
  logic [IDX_W-1:0] w_sel;
  logic             w_sel_valid;

  svc_axi_wr_sched #(.NUM_M(NUM_M), .GRANT_DEPTH(GRANT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .aw_sel(aw_sel), .w_sel(w_sel), .w_sel_valid(w_sel_valid)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad   = 0;
  logic [IDX_W-1:0] exp_aw  [$];
  logic [IDX_W-1:0] model_w [$];
  int               hs_cyc  [$];
  int               hs_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check(tag, {s_axi_awready, s_axi_wready, m_axi_awvalid, m_axi_wvalid,
                aw_sel, w_sel, w_sel_valid}, 32'd0);
  endtask

  // Per-cycle monitor: W steering against the grant-order model, AW against the scoreboard.
  task automatic sample();
    logic [IDX_W-1:0] head;
    logic             valid;
    logic             pop;
    if (rst) begin
      exp_aw.delete();
      model_w.delete();
      hs_cyc.delete();
      hs_n = 0;
    end else begin
      valid = (model_w.size() != 0);
      head  = valid ? model_w[0] : '0;
      check("w_sel_valid", w_sel_valid, valid);
      if (valid) begin
        check("w_sel", w_sel, head);
        check("m_wvalid", m_axi_wvalid, s_axi_wvalid[head]);
        check("s_wready", s_axi_wready, NUM_M'(m_axi_wready) << head);
      end else begin
        check("m_wvalid_empty", m_axi_wvalid, 1'b0);
        check("s_wready_empty", s_axi_wready, '0);
      end
      pop = valid && m_axi_wvalid && m_axi_wready && s_axi_wlast[head];
      if (pop) void'(model_w.pop_front());
      if (m_axi_awvalid) begin
        if (exp_aw.size() == 0) begin
          check("aw_unexpected", 1'b1, 1'b0);
        end else begin
          check("aw_sel", aw_sel, exp_aw[0]);
          check("s_awready", s_axi_awready, NUM_M'(m_axi_awready) << exp_aw[0]);
          if (m_axi_awready) begin
            model_w.push_back(exp_aw.pop_front());
            hs_cyc.push_back(cyc_n);
            hs_n++;
          end
        end
      end else begin
        check("s_awready_idle", s_axi_awready, '0);
      end
    end
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n = 0;
    while (hs_n < target && n < 40) begin
      step();
      n++;
    end
    check({tag, "_hs_timeout"}, hs_n >= target, 1'b1);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (model_w.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, model_w.size() == 0, 1'b1);
  endtask

  initial begin
    int b0, b1, n, tgt;
    fork
      forever begin
        @(negedge clk);
        sample();
      end
    join_none

    step(); step();
    chk_zero("reset_outputs");
    rst = 1'b0;
    step();
    chk_zero("after_release");

    // Reset during AW_HOLD with two grants queued; rr_ptr is 1 at that point.
    m_axi_awready = 1'b1;
    s_axi_awvalid = 2'b01;
    exp_aw.push_back(1'b0);
    exp_aw.push_back(1'b0);
    wait_hs(2, "t1");
    m_axi_awready = 1'b0;
    s_axi_awvalid = 2'b11;
    exp_aw.push_back(1'b1);
    step(); step();
    check("t1_hold", m_axi_awvalid, 1'b1);
    check("t1_wsel_valid", w_sel_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_zero("t1_async_reset");
    step();
    chk_zero("t1_reset_next_cycle");
    s_axi_awvalid = 2'b00;
    rst = 1'b0;
    step();

    // Both managers requesting: grants alternate starting at 0, one per 2 cycles.
    s_axi_awvalid = 2'b11;
    m_axi_awready = 1'b1;
    exp_aw.push_back(1'b0);
    exp_aw.push_back(1'b1);
    exp_aw.push_back(1'b0);
    exp_aw.push_back(1'b1);
    step();
    check("t2_latency", m_axi_awvalid, 1'b1);
    wait_hs(4, "t2");
    for (int i = 1; i < 4 && i < hs_cyc.size(); i++)
      check("t2_spacing", hs_cyc[i] - hs_cyc[i-1], 2);

    // FIFO full: the pending 5th request must not be granted until a pop.
    exp_aw.push_back(1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t4_full_awvalid", m_axi_awvalid, 1'b0);
      check("t4_full_awready", s_axi_awready, '0);
      step();
    end
    s_axi_wvalid = 2'b01;
    s_axi_wlast  = 2'b01;
    m_axi_wready = 1'b1;
    step();
    s_axi_wvalid = 2'b00;
    s_axi_wlast  = 2'b00;
    m_axi_wready = 1'b0;
    n = 0;
    while (hs_n < 5 && n < 5) begin
      step();
      n++;
    end
    check("t4_regrant_within_2", n <= 2 && hs_n == 5, 1'b1);
    s_axi_awvalid = 2'b00;
    s_axi_wvalid  = 2'b11;
    s_axi_wlast   = 2'b11;
    m_axi_wready  = 1'b1;
    wait_empty("t4");
    s_axi_wvalid  = 2'b00;
    s_axi_wlast   = 2'b00;
    m_axi_wready  = 1'b0;
    step();

    // Mgr1 then mgr0, each a 4-beat burst.
    s_axi_awvalid = 2'b10;
    exp_aw.push_back(1'b1);
    tgt = hs_n + 1;
    wait_hs(tgt, "t3a");
    s_axi_awvalid = 2'b01;
    exp_aw.push_back(1'b0);
    tgt = hs_n + 1;
    wait_hs(tgt, "t3b");
    s_axi_awvalid = 2'b00;
    m_axi_wready  = 1'b1;
    b0 = 0;
    b1 = 0;
    n  = 0;
    while ((b0 < 4 || b1 < 4) && n < 40) begin
      s_axi_wvalid = {b1 < 4, b0 < 4};
      s_axi_wlast  = {b1 == 3, b0 == 3};
      @(negedge clk);
      if (s_axi_wvalid[0] && s_axi_wready[0]) begin
        check("t3_order", b1, 4);
        b0++;
      end
      if (s_axi_wvalid[1] && s_axi_wready[1]) b1++;
      step();
      n++;
    end
    check("t3_beats_m0", b0, 4);
    check("t3_beats_m1", b1, 4);
    s_axi_wvalid = 2'b00;
    s_axi_wlast  = 2'b00;
    m_axi_wready = 1'b0;
    step();

    // Single-beat pop in the same cycle as an AW push.
    s_axi_awvalid = 2'b01;
    exp_aw.push_back(1'b0);
    tgt = hs_n + 1;
    wait_hs(tgt, "t5a");
    m_axi_awready = 1'b0;
    s_axi_awvalid = 2'b10;
    exp_aw.push_back(1'b1);
    step();
    check("t5_hold", m_axi_awvalid, 1'b1);
    s_axi_wvalid  = 2'b01;
    s_axi_wlast   = 2'b01;
    m_axi_wready  = 1'b1;
    m_axi_awready = 1'b1;
    step();
    s_axi_wvalid  = 2'b00;
    s_axi_wlast   = 2'b00;
    m_axi_wready  = 1'b0;
    s_axi_awvalid = 2'b00;
    check("t5_wsel_adv", w_sel, 1'b1);
    check("t5_count_kept", w_sel_valid, 1'b1);
    check("t5_aw_idle", m_axi_awvalid, 1'b0);
    s_axi_wvalid = 2'b10;
    s_axi_wlast  = 2'b10;
    m_axi_wready = 1'b1;
    step();
    s_axi_wvalid = 2'b00;
    s_axi_wlast  = 2'b00;
    m_axi_wready = 1'b0;
    check("t5_empty", w_sel_valid, 1'b0);

    // W from mgr1 before its AW grant stalls.
    s_axi_wvalid = 2'b10;
    s_axi_wlast  = 2'b10;
    m_axi_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_stall_wvalid", m_axi_wvalid, 1'b0);
      check("t6_stall_wready", s_axi_wready, '0);
    end
    s_axi_awvalid = 2'b10;
    m_axi_awready = 1'b1;
    exp_aw.push_back(1'b1);
    tgt = hs_n + 1;
    wait_hs(tgt, "t6");
    s_axi_awvalid = 2'b00;
    wait_empty("t6");
    s_axi_wvalid = 2'b00;
    s_axi_wlast  = 2'b00;
    m_axi_wready = 1'b0;
    step();
    check("t6_done", w_sel_valid, 1'b0);
    check("sb_drained", exp_aw.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
